// File: rtl/com_bus_arbiter_if.sv
// Request/grant bundle between the cache array and the common-bus arbiter.
// The slave modport is the arbiter side; master is the requester side.
interface com_bus_arbiter_if #(
    parameter int unsigned NUM_PROC  = 8,
    parameter int unsigned NUM_SNOOP = 4,
    parameter int unsigned ID_W      = 3,
    parameter int unsigned SID_W     = 2
);
    logic [NUM_PROC-1:0]  Com_Bus_Req_proc;
    logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc;
    logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop;
    logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop;
    logic                 Bus_busy;
    logic [ID_W-1:0]      Proc_owner;
    logic [SID_W-1:0]     Snoop_owner;
    logic                 Hold_timeout;

    modport master (
        output Com_Bus_Req_proc,
        output Com_Bus_Req_snoop,
        input  Com_Bus_Gnt_proc,
        input  Com_Bus_Gnt_snoop,
        input  Bus_busy,
        input  Proc_owner,
        input  Snoop_owner,
        input  Hold_timeout
    );

    modport slave (
        input  Com_Bus_Req_proc,
        input  Com_Bus_Req_snoop,
        output Com_Bus_Gnt_proc,
        output Com_Bus_Gnt_snoop,
        output Bus_busy,
        output Proc_owner,
        output Snoop_owner,
        output Hold_timeout
    );
endinterface

// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter: round-robin proc lane with a turnaround dead cycle,
// plus an independent round-robin snoop lane. All outputs registered.
module com_bus_arbiter #(
    parameter int unsigned NUM_PROC  = 8,
    parameter int unsigned NUM_SNOOP = 4,
    parameter int unsigned ID_W      = 3,
    parameter int unsigned MAX_HOLD  = 256
) (
    input logic              clk,
    input logic              rst,
    com_bus_arbiter_if.slave bus
);
    localparam int unsigned SID_W  = (NUM_SNOOP > 1) ? $clog2(NUM_SNOOP) : 1;
    localparam int unsigned PW     = ID_W + 1;
    localparam int unsigned SPW    = SID_W + 1;
    localparam int unsigned HCNT_W = $clog2(MAX_HOLD + 1);

    localparam logic [HCNT_W-1:0] HOLD_LIMIT = HCNT_W'(MAX_HOLD);
    localparam logic [ID_W-1:0]   PROC_LAST  = ID_W'(NUM_PROC - 1);
    localparam logic [SID_W-1:0]  SNOOP_LAST = SID_W'(NUM_SNOOP - 1);

    typedef enum logic [1:0] {StIdle, StGrant, StRelease} proc_state_e;

    logic [NUM_PROC-1:0]  w_req_proc;
    logic [NUM_SNOOP-1:0] w_req_snoop;
    logic [ID_W-1:0]      w_proc_pick;
    logic [SID_W-1:0]     w_snoop_pick;

    proc_state_e          r_state;
    logic [NUM_PROC-1:0]  r_gnt_proc;
    logic                 r_busy;
    logic [ID_W-1:0]      r_proc_owner;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [HCNT_W-1:0]    r_hold_cnt;
    logic                 r_hold_timeout;
    logic [NUM_SNOOP-1:0] r_gnt_snoop;
    logic [SID_W-1:0]     r_snoop_owner;
    logic [SID_W-1:0]     r_snoop_ptr;

    assign w_req_proc  = bus.Com_Bus_Req_proc;
    assign w_req_snoop = bus.Com_Bus_Req_snoop;

    // First set bit at or above ptr, wrapping; ptr and k are both below NUM_PROC.
    function automatic logic [ID_W-1:0] pick_proc(input logic [NUM_PROC-1:0] req,
                                                  input logic [ID_W-1:0]     ptr);
        logic [ID_W-1:0] pick;
        logic [PW-1:0]   sum;
        logic            found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_PROC; k++) begin
            sum = {1'b0, ptr} + PW'(k);
            if (sum >= PW'(NUM_PROC)) sum = sum - PW'(NUM_PROC);
            if (!found && req[sum[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = sum[ID_W-1:0];
            end
        end
        return pick;
    endfunction

    function automatic logic [SID_W-1:0] pick_snoop(input logic [NUM_SNOOP-1:0] req,
                                                    input logic [SID_W-1:0]     ptr);
        logic [SID_W-1:0] pick;
        logic [SPW-1:0]   sum;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_SNOOP; k++) begin
            sum = {1'b0, ptr} + SPW'(k);
            if (sum >= SPW'(NUM_SNOOP)) sum = sum - SPW'(NUM_SNOOP);
            if (!found && req[sum[SID_W-1:0]]) begin
                found = 1'b1;
                pick  = sum[SID_W-1:0];
            end
        end
        return pick;
    endfunction

    assign w_proc_pick  = pick_proc(w_req_proc, r_rr_ptr);
    assign w_snoop_pick = pick_snoop(w_req_snoop, r_snoop_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= StIdle;
            r_gnt_proc     <= '0;
            r_busy         <= 1'b0;
            r_proc_owner   <= '0;
            r_rr_ptr       <= '0;
            r_hold_cnt     <= '0;
            r_hold_timeout <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (|w_req_proc) begin
                        r_gnt_proc   <= NUM_PROC'(1) << w_proc_pick;
                        r_proc_owner <= w_proc_pick;
                        r_busy       <= 1'b1;
                        r_hold_cnt   <= '0;
                        r_state      <= StGrant;
                    end
                end
                StGrant: begin
                    if (w_req_proc[r_proc_owner]) begin
                        // Timeout only flags; the owner keeps the bus.
                        if (r_hold_cnt != HOLD_LIMIT) begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                            if (r_hold_cnt + 1'b1 == HOLD_LIMIT) r_hold_timeout <= 1'b1;
                        end
                    end else begin
                        r_gnt_proc <= '0;
                        r_busy     <= 1'b0;
                        r_rr_ptr   <= (r_proc_owner == PROC_LAST) ? '0 : r_proc_owner + 1'b1;
                        r_state    <= StRelease;
                    end
                end
                StRelease: r_state <= StIdle;
                default:   r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt_snoop   <= '0;
            r_snoop_owner <= '0;
            r_snoop_ptr   <= '0;
        end else if (r_gnt_snoop == '0) begin
            if (|w_req_snoop) begin
                r_gnt_snoop   <= NUM_SNOOP'(1) << w_snoop_pick;
                r_snoop_owner <= w_snoop_pick;
            end
        end else if (!w_req_snoop[r_snoop_owner]) begin
            r_gnt_snoop <= '0;
            r_snoop_ptr <= (r_snoop_owner == SNOOP_LAST) ? '0 : r_snoop_owner + 1'b1;
        end
    end

    assign bus.Com_Bus_Gnt_proc  = r_gnt_proc;
    assign bus.Com_Bus_Gnt_snoop = r_gnt_snoop;
    assign bus.Bus_busy          = r_busy;
    assign bus.Proc_owner        = r_proc_owner;
    assign bus.Snoop_owner       = r_snoop_owner;
    assign bus.Hold_timeout      = r_hold_timeout;

    a_proc_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt_proc));
    a_snoop_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt_snoop));
    a_proc_had_req: assert property (@(posedge clk) disable iff (rst)
        (r_gnt_proc & ~$past(w_req_proc)) == '0);
    a_snoop_had_req: assert property (@(posedge clk) disable iff (rst)
        (r_gnt_snoop & ~$past(w_req_snoop)) == '0);
endmodule

// File: tb/tb_com_bus_arbiter.sv
// Bench for com_bus_arbiter: directed scenarios plus random traffic, all scored
// against an integer-level arbitration model through an expectation queue.
module tb_com_bus_arbiter;
    localparam int NP   = 8;
    localparam int NS   = 4;
    localparam int MAXH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    com_bus_arbiter_if bus_if ();

    com_bus_arbiter #(
        .NUM_PROC (NP),
        .NUM_SNOOP(NS),
        .ID_W     (3),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] gp;
        logic [3:0] gs;
        logic       busy;
        logic [2:0] po;
        logic [1:0] so;
        logic       to;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   got_order[$];

    // Reference model: owner (-1 = none), pointers and ages as plain integers.
    int m_po, m_plast, m_rr, m_hold, m_so, m_slast, m_sptr;
    bit m_dead, m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t dut_obs();
        obs_t o;
        o.gp   = bus_if.Com_Bus_Gnt_proc;
        o.gs   = bus_if.Com_Bus_Gnt_snoop;
        o.busy = bus_if.Bus_busy;
        o.po   = bus_if.Proc_owner;
        o.so   = bus_if.Snoop_owner;
        o.to   = bus_if.Hold_timeout;
        return o;
    endfunction

    task automatic model_reset();
        m_po = -1; m_plast = 0; m_rr = 0; m_hold = 0; m_dead = 0; m_to = 0;
        m_so = -1; m_slast = 0; m_sptr = 0;
    endtask

    task automatic model_step(input logic [7:0] rp, input logic [3:0] rs);
        int idx;
        if (m_po >= 0) begin
            if (rp[m_po[2:0]]) begin
                if (m_hold < MAXH) m_hold++;
                if (m_hold == MAXH) m_to = 1;
            end else begin
                m_rr   = (m_po + 1) % NP;
                m_po   = -1;
                m_dead = 1;
            end
        end else if (m_dead) begin
            m_dead = 0;
        end else begin
            for (int k = 0; k < NP; k++) begin
                idx = (m_rr + k) % NP;
                if (m_po < 0 && rp[idx[2:0]]) begin
                    m_po = idx; m_plast = idx; m_hold = 0;
                end
            end
        end
        if (m_so >= 0) begin
            if (!rs[m_so[1:0]]) begin
                m_sptr = (m_so + 1) % NS;
                m_so   = -1;
            end
        end else begin
            for (int k = 0; k < NS; k++) begin
                idx = (m_sptr + k) % NS;
                if (m_so < 0 && rs[idx[1:0]]) begin
                    m_so = idx; m_slast = idx;
                end
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.gp   = (m_po >= 0) ? (8'd1 << m_po) : 8'd0;
        o.gs   = (m_so >= 0) ? (4'd1 << m_so) : 4'd0;
        o.busy = (m_po >= 0);
        o.po   = m_plast[2:0];
        o.so   = m_slast[1:0];
        o.to   = m_to;
        return o;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
                exp_q.delete();
            end else begin
                model_step(bus_if.Com_Bus_Req_proc, bus_if.Com_Bus_Req_snoop);
                exp_q.push_back(model_obs());
            end
        end
    end

    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", 32'(dut_obs()), 32'(e));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_if.Com_Bus_Req_proc  = '0;
        bus_if.Com_Bus_Req_snoop = '0;
        repeat (2) @(negedge clk);
        check("reset_state", 32'(dut_obs()), 32'(0));
        rst = 1'b0;
    endtask

    // Each owner drops its request after `hold` granted cycles; optionally re-requests.
    task automatic run_rr(input logic [7:0] mask, input int hold, input int n, input bit rearm);
        int cur = -1, cnt = 0, rel = 0, pend = -1, budget = 0, idx = 0;
        logic [7:0] g;
        bus_if.Com_Bus_Req_proc = mask;
        while (!(rel == n && bus_if.Com_Bus_Gnt_proc == '0) && budget < 400) begin
            @(negedge clk);
            budget++;
            g = bus_if.Com_Bus_Gnt_proc;
            if (g != '0) begin
                for (int i = 0; i < NP; i++) if (g[i[2:0]]) idx = i;
                if (idx != cur) begin
                    got_order.push_back(idx);
                    cur = idx;
                    cnt = 0;
                end
                cnt++;
                if (cnt == hold) begin
                    bus_if.Com_Bus_Req_proc[idx[2:0]] = 1'b0;
                    rel++;
                    if (rearm) pend = idx;
                end
            end else begin
                cur = -1;
                if (pend >= 0) begin
                    bus_if.Com_Bus_Req_proc[pend[2:0]] = 1'b1;
                    pend = -1;
                end
            end
        end
        check("rr_releases", 32'(rel), 32'(n));
    endtask

    task automatic check_order(input string name, input int exp[$]);
        check({name, "_len"}, 32'(got_order.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got_order.size()) check(name, 32'(got_order[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        int exp_rr[$];
        bus_if.Com_Bus_Req_proc  = '0;
        bus_if.Com_Bus_Req_snoop = '0;

        // Single request: 1-cycle latency, release, then rr_ptr = 3 observed.
        do_reset();
        bus_if.Com_Bus_Req_proc = 8'h04;
        @(negedge clk);
        check("single_gnt", 32'(bus_if.Com_Bus_Gnt_proc), 32'h04);
        check("single_owner", 32'(bus_if.Proc_owner), 32'd2);
        check("single_busy", 32'(bus_if.Bus_busy), 32'd1);
        repeat (4) @(negedge clk);
        bus_if.Com_Bus_Req_proc = 8'h00;
        @(negedge clk);
        check("single_drop_gnt", 32'(bus_if.Com_Bus_Gnt_proc), 32'h00);
        check("single_drop_busy", 32'(bus_if.Bus_busy), 32'd0);
        check("single_hold_owner", 32'(bus_if.Proc_owner), 32'd2);
        bus_if.Com_Bus_Req_proc = 8'h09;
        @(negedge clk);
        check("dead_cycle", 32'(bus_if.Com_Bus_Gnt_proc), 32'h00);
        @(negedge clk);
        check("rr_ptr_3", 32'(bus_if.Com_Bus_Gnt_proc), 32'h08);
        bus_if.Com_Bus_Req_proc = 8'h00;
        repeat (3) @(negedge clk);

        // Full round robin.
        do_reset();
        got_order.delete();
        run_rr(8'hFF, 2, 9, 1'b1);
        exp_rr.delete();
        for (int i = 0; i < 9; i++) exp_rr.push_back(i % NP);
        check_order("rr_order", exp_rr);

        // Wrap from rr_ptr = 6.
        do_reset();
        got_order.delete();
        run_rr(8'h20, 2, 1, 1'b0);
        run_rr(8'h03, 2, 2, 1'b0);
        check_order("wrap_03", '{5, 0, 1});
        do_reset();
        got_order.delete();
        run_rr(8'h20, 2, 1, 1'b0);
        run_rr(8'hC1, 2, 3, 1'b0);
        check_order("wrap_c1", '{5, 6, 7, 0});

        // Snoop lane alongside a proc grant.
        do_reset();
        bus_if.Com_Bus_Req_proc = 8'h10;
        @(negedge clk);
        check("cs_proc", 32'(bus_if.Com_Bus_Gnt_proc), 32'h10);
        bus_if.Com_Bus_Req_snoop = 4'b1010;
        @(negedge clk);
        check("cs_snoop1", 32'(bus_if.Com_Bus_Gnt_snoop), 32'b0010);
        check("cs_sowner1", 32'(bus_if.Snoop_owner), 32'd1);
        bus_if.Com_Bus_Req_snoop = 4'b1000;
        @(negedge clk);
        check("cs_snoop_drop", 32'(bus_if.Com_Bus_Gnt_snoop), 32'b0000);
        @(negedge clk);
        check("cs_snoop3", 32'(bus_if.Com_Bus_Gnt_snoop), 32'b1000);
        check("cs_sowner3", 32'(bus_if.Snoop_owner), 32'd3);
        check("cs_proc_kept", 32'(bus_if.Com_Bus_Gnt_proc), 32'h10);
        bus_if.Com_Bus_Req_proc  = '0;
        bus_if.Com_Bus_Req_snoop = '0;
        repeat (3) @(negedge clk);

        // Hold timeout at ownership cycle MAXH+1, sticky after release.
        do_reset();
        bus_if.Com_Bus_Req_proc = 8'h02;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("timeout_flag", 32'(bus_if.Hold_timeout), 32'(k >= MAXH + 1));
            check("timeout_gnt", 32'(bus_if.Com_Bus_Gnt_proc), 32'h02);
        end
        bus_if.Com_Bus_Req_proc = 8'h00;
        @(negedge clk);
        check("timeout_sticky", 32'(bus_if.Hold_timeout), 32'd1);
        check("timeout_released", 32'(bus_if.Com_Bus_Gnt_proc), 32'h00);

        // Asynchronous reset mid-transaction.
        do_reset();
        bus_if.Com_Bus_Req_proc  = 8'h20;
        bus_if.Com_Bus_Req_snoop = 4'h1;
        @(negedge clk);
        check("mid_proc", 32'(bus_if.Com_Bus_Gnt_proc), 32'h20);
        check("mid_snoop", 32'(bus_if.Com_Bus_Gnt_snoop), 32'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst_outputs", 32'(dut_obs()), 32'(0));
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(bus_if.Com_Bus_Gnt_proc), 32'h00);
        @(negedge clk);
        check("post_rst_proc", 32'(bus_if.Com_Bus_Gnt_proc), 32'h20);
        check("post_rst_owner", 32'(bus_if.Proc_owner), 32'd5);
        check("post_rst_snoop", 32'(bus_if.Com_Bus_Gnt_snoop), 32'h1);

        // Random traffic: owners drop after a while, waiters occasionally give up.
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) begin
                if (bus_if.Com_Bus_Req_proc[i[2:0]]) begin
                    if (bus_if.Com_Bus_Gnt_proc[i[2:0]]) begin
                        if ($urandom_range(0, 3) == 0) bus_if.Com_Bus_Req_proc[i[2:0]] = 1'b0;
                    end else if ($urandom_range(0, 15) == 0) begin
                        bus_if.Com_Bus_Req_proc[i[2:0]] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    bus_if.Com_Bus_Req_proc[i[2:0]] = 1'b1;
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (bus_if.Com_Bus_Req_snoop[i[1:0]]) begin
                    if (bus_if.Com_Bus_Gnt_snoop[i[1:0]]) begin
                        if ($urandom_range(0, 2) == 0) bus_if.Com_Bus_Req_snoop[i[1:0]] = 1'b0;
                    end else if ($urandom_range(0, 15) == 0) begin
                        bus_if.Com_Bus_Req_snoop[i[1:0]] = 1'b0;
                    end
                end else if ($urandom_range(0, 4) == 0) begin
                    bus_if.Com_Bus_Req_snoop[i[1:0]] = 1'b1;
                end
            end
        end
        bus_if.Com_Bus_Req_proc  = '0;
        bus_if.Com_Bus_Req_snoop = '0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/com_bus_arbiter.md
Name: com_bus_arbiter

Overview:
- Arbitrates the shared common bus (Address_Com / Data_Bus_Com) among the 8 processor-side requesters of the multi-core cache subsystem and the 4 data-cache snoop responders.
- Processor-side requesters are data caches 0-3 and instruction caches 4-7. Snoop responders are data caches 0-3.
- Consumes Com_Bus_Req_proc / Com_Bus_Req_snoop from the cache array and produces the matching Com_Bus_Gnt_proc / Com_Bus_Gnt_snoop.
- Processor grants use round-robin fairness with one dead cycle between owners. Snoop grants run in a nested, concurrent lane.

Parameters:
- NUM_PROC, 8, number of processor-side requesters.
- NUM_SNOOP, 4, number of snoop requesters.
- ID_W, 3, width of the owner index outputs (ceil log2 NUM_PROC).
- MAX_HOLD, 256, cycle count after which a continuous proc grant raises Hold_timeout.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- Com_Bus_Req_proc  input  NUM_PROC  bus request per processor-side cache, level, held until transaction done.
- Com_Bus_Gnt_proc  output  NUM_PROC  one-hot-or-zero proc grant.
- Com_Bus_Req_snoop  input  NUM_SNOOP  snoop flush/response request per data cache.
- Com_Bus_Gnt_snoop  output  NUM_SNOOP  one-hot-or-zero snoop grant.
- Bus_busy  output  1  high while any proc grant is asserted.
- Proc_owner  output  ID_W  index of current proc grantee; holds last owner when idle.
- Snoop_owner  output  2  index of current snoop grantee; holds last owner when idle.
- Hold_timeout  output  1  sticky error flag, cleared only by rst.

Behaviour:
- Reset (async, immediate) drives all outputs to 0: Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Bus_busy, Proc_owner, Snoop_owner, Hold_timeout. Also rr_ptr=0, snoop_ptr=0, hold_cnt=0, and the proc FSM enters IDLE.
- Deasserting rst mid-transaction does not restore any grant. Requesters re-arbitrate from IDLE.
- All outputs are registered. No combinational path from requests to grants.
- Proc FSM states: IDLE, GRANT, RELEASE.
  - IDLE: if any Com_Bus_Req_proc bit is set, pick the first set bit searching from rr_ptr upward with wrap (NUM_PROC-1 -> 0). Next edge: assert that grant, load Proc_owner, set Bus_busy, clear hold_cnt, go to GRANT. Grant latency from a request seen in IDLE is 1 cycle.
  - GRANT: hold the grant while the owner's request stays high, regardless of other requests. hold_cnt increments, saturating at MAX_HOLD. When hold_cnt reaches MAX_HOLD, set Hold_timeout. The grant is not revoked.
  - GRANT -> RELEASE: owner's request sampled low. Next edge: grant=0, Bus_busy=0, rr_ptr = owner+1 mod NUM_PROC.
  - RELEASE: exactly one dead cycle with no proc grant, for tri-state turnaround on Address_Com/Data_Bus_Com. Then go to IDLE. The next grant appears no earlier than 2 cycles after the release edge.
- Snoop lane runs independently of the proc FSM and may be granted concurrently with a proc grant. At most one snoop grant at a time.
  - No snoop grant active and any Com_Bus_Req_snoop set: grant the first set bit from snoop_ptr with wrap on the next edge and load Snoop_owner.
  - Hold while that request is high. Drop the cycle after it falls and set snoop_ptr = owner+1 mod NUM_SNOOP.
  - No dead cycle in the snoop lane; a new snoop grant may issue on the edge after the drop.
- Simultaneous events:
  - A request rising in the same cycle the current owner releases waits for RELEASE/IDLE.
  - A request that drops before being granted is simply not granted; there is no latching of requests.
  - A snoop request from cache i while proc grant i is active is legal and granted normally.
- Invariants, all checked by assertions:
  - Com_Bus_Gnt_proc is never multi-hot.
  - Com_Bus_Gnt_snoop is never multi-hot.
  - A grant is never asserted to a requester whose request was low on the previous edge.

Test Plan:
- Single request: rst, then Com_Bus_Req_proc=8'h04 at cycle 0 -> Gnt_proc=8'h04, Proc_owner=2, Bus_busy=1 at cycle 1. Drop request at cycle 5 -> Gnt_proc=0 at cycle 6; rr_ptr=3.
- Round-robin: all 8 requests held high, each releasing after 2 granted cycles -> grant order 0,1,2,...,7,0, with one dead cycle between every pair. Gnt_proc is never multi-hot.
- Wrap: rr_ptr=6 (after serving 5), requests 8'h03 -> owner 0 then 1. Requests 8'hC1 with rr_ptr=6 -> order 6,7,0.
- Concurrent snoop: proc grant to 4 (I-cache 0) active, Com_Bus_Req_snoop=4'b1010 -> Gnt_snoop=4'b0010 next cycle. Release -> 4'b1000 on the following edge. Gnt_proc=8'h10 is unaffected throughout.
- Timeout: MAX_HOLD=8, proc 1 holds its request 20 cycles -> Hold_timeout=1 from cycle 9 of ownership and stays 1 after release. Grant to 1 persists all 20 cycles.
- Reset mid-op: grants 8'h20 and 4'h1 active, pulse rst asynchronously between edges -> both grants 0 immediately. After rst low with requests still high, proc grant to 5 is reissued 1 cycle after the first edge, from IDLE with rr_ptr=0.
